// File: rtl/gamepad_pmod_pkg.sv
// Definitions shared by the gamepad Pmod transmitter and receiver: button
// bit positions, frame geometry, link state encoding and frame packing.
package gamepad_pmod_pkg;

  localparam int CTRL_BITS  = 12;
  localparam int FRAME_BITS = 2 * CTRL_BITS;

  localparam logic [CTRL_BITS-1:0] ABSENT_WORD = 12'hFFF;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    TAIL     = 3'd4
  } pmod_state_e;

  // Controller 2 goes in the upper half so it is shifted out first and
  // controller 1 ends up in the receiver's low 12 bits.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [CTRL_BITS-1:0] buttons1,
    input logic [CTRL_BITS-1:0] buttons2,
    input logic                 present1,
    input logic                 present2
  );
    logic [CTRL_BITS-1:0] w1;
    logic [CTRL_BITS-1:0] w2;
    w1 = present1 ? buttons1 : ABSENT_WORD;
    w2 = present2 ? buttons2 : ABSENT_WORD;
    return {w2, w1};
  endfunction

endpackage

// File: rtl/gamepad_pmod_tx.sv
// Transmit end of the gamepad Pmod link: serialises two 12-bit button words
// MSB-first on pmod_clk/pmod_data and commits them with a latch strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | pins low, waiting for i_send
//   SHIFT_LO | pmod_clk low, pmod_data = current MSB (CLK_DIV cycles)
//   SHIFT_HI | pmod_clk high, data held; shift word on exit (CLK_DIV cycles)
//   LATCH    | pmod_latch high, commits frame in receiver (CLK_DIV cycles)
//   TAIL     | all pins low before o_done and return to IDLE (CLK_DIV cycles)
module gamepad_pmod_tx
  import gamepad_pmod_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int NUM_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_send,
  input  logic [CTRL_BITS-1:0] i_buttons1,
  input  logic [CTRL_BITS-1:0] i_buttons2,
  input  logic                 i_present1,
  input  logic                 i_present2,
  output logic                 o_pmod_latch,
  output logic                 o_pmod_clk,
  output logic                 o_pmod_data,
  output logic                 o_busy,
  output logic                 o_done
);

  // The receiver needs a 2-FF synchroniser plus edge detect per pmod_clk edge.
  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("gamepad_pmod_tx: CLK_DIV must be >= 4");
  end
  if (NUM_BITS != FRAME_BITS) begin : g_bad_num_bits
    $error("gamepad_pmod_tx: NUM_BITS must equal 2 x CTRL_BITS");
  end

  localparam int                PH_W     = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0]   PH_LOAD  = PH_W'(CLK_DIV - 1);
  localparam logic [4:0]        LAST_BIT = 5'(NUM_BITS - 1);

  pmod_state_e            state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [4:0]             bit_q, bit_d;
  logic [FRAME_BITS-1:0]  word_q, word_d;
  logic                   latch_q, latch_d;
  logic                   pclk_q, pclk_d;
  logic                   data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ph_tc;

  assign ph_tc = (phase_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    word_d  = word_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (i_send) begin
          word_d  = pack_frame(i_buttons1, i_buttons2, i_present1, i_present2);
          phase_d = PH_LOAD;
          bit_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (ph_tc) begin
          phase_d = PH_LOAD;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (ph_tc) begin
          phase_d = PH_LOAD;
          word_d  = {word_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SHIFT_LO;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      LATCH: begin
        if (ph_tc) begin
          phase_d = PH_LOAD;
          state_d = TAIL;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      TAIL: begin
        if (ph_tc) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    // Pins are decoded from the next state so they register in step with it.
    pclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    data_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && word_d[FRAME_BITS-1];
    busy_d  = (state_d != IDLE);
  end

  assign o_pmod_latch = latch_q;
  assign o_pmod_clk   = pclk_q;
  assign o_pmod_data  = data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Self-checking bench for gamepad_pmod_tx: frame-level reference model
// checked every cycle, plus a bench-side receiver and literal expectations.
module tb_gamepad_pmod_tx;

  localparam int CD = 4;
  localparam int FL = 50 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_send = 1'b0;
  logic [11:0] b1 = 12'h000;
  logic [11:0] b2 = 12'h000;
  logic        p1 = 1'b0;
  logic        p2 = 1'b0;
  logic        o_pmod_latch, o_pmod_clk, o_pmod_data, o_busy, o_done;

  gamepad_pmod_tx #(.CLK_DIV(CD), .NUM_BITS(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_send       (i_send),
    .i_buttons1   (b1),
    .i_buttons2   (b2),
    .i_present1   (p1),
    .i_present2   (p2),
    .o_pmod_latch (o_pmod_latch),
    .o_pmod_clk   (o_pmod_clk),
    .o_pmod_data  (o_pmod_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Frame-level model: mn = cycles since the accept edge, -1 when idle.
  int          mn = -1;
  logic [23:0] mword = '0;
  logic        mdone = 1'b0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    mdone = 1'b0;
    if (rst) begin
      mn = -1;
      armed = 1'b1;
    end else if (mn < 0) begin
      if (i_send) begin
        mword = {(p2 ? b2 : 12'hFFF), (p1 ? b1 : 12'hFFF)};
        mn = 0;
      end
    end else if (mn == FL - 1) begin
      mn = -1;
      mdone = 1'b1;
    end else begin
      mn++;
    end
  end

  // {latch, clk, data, busy, done}
  function automatic logic [4:0] expect_pins(input int n, input logic [23:0] w, input logic d);
    int slot;
    int bi;
    if (n < 0) return {4'b0000, d};
    slot = n / CD;
    if (slot < 48) begin
      bi = slot / 2;
      return {1'b0, (slot % 2 == 1), w[23 - bi], 1'b1, 1'b0};
    end
    if (slot == 48) return 5'b10010;
    return 5'b00010;
  endfunction

  always @(negedge clk) begin
    if (armed)
      chk("pins", {27'd0, o_pmod_latch, o_pmod_clk, o_pmod_data, o_busy, o_done},
          {27'd0, expect_pins(mn, mword, mdone)});
  end

  // Bench receiver: shifts on pmod_clk rising, commits at end of latch pulse.
  logic        pclk = 1'b0;
  logic        platch = 1'b0;
  int          lat_len = 0;
  int          rx_edges = 0;
  int          n_latches = 0;
  logic [23:0] rx_sh = '0;
  logic [23:0] rx_frame = '0;

  always @(negedge clk) begin
    if (rst) begin
      rx_edges = 0;
      lat_len = 0;
    end else begin
      if (o_pmod_clk === 1'b1 && !pclk) begin
        rx_sh = {rx_sh[22:0], o_pmod_data};
        rx_edges++;
      end
      if (o_pmod_latch === 1'b1) begin
        lat_len++;
      end else if (platch) begin
        chk("latch_width", lat_len, CD);
        chk("clk_edges_per_frame", rx_edges, 24);
        rx_frame = rx_sh;
        n_latches++;
        lat_len = 0;
        rx_edges = 0;
      end
    end
    pclk = (o_pmod_clk === 1'b1);
    platch = (o_pmod_latch === 1'b1);
  end

  task automatic send_frame(input logic [11:0] nb1, input logic [11:0] nb2,
                            input logic np1, input logic np2,
                            input int ignore_at, output int lat);
    int a;
    b1 = nb1; b2 = nb2; p1 = np1; p2 = np2;
    i_send = 1'b1;
    @(negedge clk);
    a = cyc;
    i_send = 1'b0;
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      if (k == ignore_at) begin
        i_send = 1'b1;
        b1 = ~nb1;
        b2 = ~nb2;
      end else begin
        i_send = 1'b0;
      end
      @(negedge clk);
      if (o_done === 1'b1) begin
        lat = cyc - a;
        break;
      end
    end
    i_send = 1'b0;
  endtask

  initial begin
    int lat;
    int nl0;
    int t0;
    int ndone;
    int last_done;
    logic [23:0] keep;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_pins", {28'd0, o_pmod_latch, o_pmod_clk, o_pmod_data, o_busy}, 32'd0);
    chk("reset_no_edges", rx_edges, 0);

    // Loopback: only start on controller 1, controller 2 absent.
    send_frame(12'h100, 12'h0F0, 1'b1, 1'b0, -1, lat);
    chk("loop_latency", lat, FL);
    repeat (2) @(negedge clk);
    chk("loop_frame", {8'd0, rx_frame}, 32'hFFF100);
    chk("loop_start", {31'd0, rx_frame[8]}, 32'd1);
    chk("loop_present", {31'd0, rx_frame[11:0] != 12'hFFF}, 32'd1);

    // Controller 1 absent.
    send_frame(12'h0FF, 12'h000, 1'b0, 1'b1, -1, lat);
    chk("absent_latency", lat, FL);
    repeat (2) @(negedge clk);
    chk("absent_frame", {8'd0, rx_frame}, 32'h000FFF);
    chk("absent_present", {31'd0, rx_frame[11:0] != 12'hFFF}, 32'd0);

    // A5A5A5 with a second request around cycle 50 that must be ignored.
    nl0 = n_latches;
    send_frame(12'h5A5, 12'hA5A, 1'b1, 1'b1, 49, lat);
    chk("a5_latency", lat, FL);
    repeat (2) @(negedge clk);
    chk("a5_frame", {8'd0, rx_frame}, 32'hA5A5A5);
    chk("a5_one_latch", n_latches - nl0, 1);
    repeat (5) @(negedge clk);
    chk("a5_second_ignored", {31'd0, o_busy}, 32'd0);

    // Reset during bit 10: no latch, receiver keeps A5A5A5.
    keep = rx_frame;
    nl0 = n_latches;
    b1 = 12'h456; b2 = 12'h123; p1 = 1'b1; p2 = 1'b1;
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    repeat (83) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pins", {27'd0, o_pmod_latch, o_pmod_clk, o_pmod_data, o_busy, o_done}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_keep", {8'd0, rx_frame}, {8'd0, keep});
    chk("midrst_no_latch", n_latches - nl0, 0);
    send_frame(12'h456, 12'h123, 1'b1, 1'b1, -1, lat);
    chk("after_rst_latency", lat, FL);
    repeat (2) @(negedge clk);
    chk("after_rst_frame", {8'd0, rx_frame}, 32'h123456);

    // Back-to-back with i_send held for 1000 cycles.
    nl0 = n_latches;
    ndone = 0;
    b1 = 12'h3C3; b2 = 12'hC3C; p1 = 1'b1; p2 = 1'b1;
    i_send = 1'b1;
    @(negedge clk);
    t0 = cyc;
    last_done = t0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        chk("b2b_interval", cyc - last_done, (ndone == 0) ? FL : FL + 1);
        last_done = cyc;
        ndone++;
      end
    end
    i_send = 1'b0;
    chk("b2b_done_count", ndone, 4);
    chk("b2b_latch_count", n_latches - nl0, 4);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        lat = cyc - last_done;
        break;
      end
    end
    chk("b2b_fifth", lat, FL + 1);
    repeat (3) @(negedge clk);
    chk("b2b_idle", {31'd0, o_busy}, 32'd0);
    chk("b2b_frame", {8'd0, rx_frame}, 32'hC3C3C3);
    chk("b2b_total_latches", n_latches - nl0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gamepad_pmod_tx.md
Name: gamepad_pmod_tx

Overview:
- Transmit end of the gamepad Pmod serial link. It generates pmod_latch, pmod_clk and pmod_data from two parallel 12-bit button words.
- Uses: on-chip loopback self-test of gamepad_pmod_single, simulation stimulus, and an optional "virtual gamepad" output on uio pins.
- One frame = 24 data bits shifted MSB-first, followed by a latch pulse. The latch commits the frame in the receiver.

Parameters:
- CLK_DIV, 4: system clocks per pmod_clk half-period. Must be ≥4 so the receiver's 2-FF synchronizer and edge detector resolve every edge. Elaboration error if <4.
- NUM_BITS, 24: frame length. Fixed at 2×12; any other value is an elaboration error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_send  in  1  frame request; accepted only in IDLE
- i_buttons1  in  12  controller 1: [11]b [10]y [9]select [8]start [7]up [6]down [5]left [4]right [3]a [2]x [1]l [0]r; active-high
- i_buttons2  in  12  controller 2, same mapping
- i_present1  in  1  0 → controller 1 word is replaced by 12'hFFF (absent)
- i_present2  in  1  same, for controller 2
- o_pmod_latch  out  1  latch strobe
- o_pmod_clk  out  1  shift clock; receiver samples on its rising edge
- o_pmod_data  out  1  serial data
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register and counters 0.
- Accept: when i_send=1 in IDLE, capture word = {p2?i_buttons2:12'hFFF, p1?i_buttons1:12'hFFF} in the same edge. o_busy=1 from the next cycle. Inputs are ignored after capture.
- i_send while busy is ignored. Nothing is queued.
- State machine (one phase counter of 0..CLK_DIV-1, one bit counter of 0..23):
  - IDLE: clk=0, latch=0, data=0.
  - SHIFT_LO (CLK_DIV cycles): data=word[23], clk=0.
  - SHIFT_HI (CLK_DIV cycles): clk=1, data held. On exit: word <<= 1, bit_cnt++. If bit_cnt was 23 → LATCH, else → SHIFT_LO.
  - LATCH (CLK_DIV cycles): latch=1, clk=0, data=0.
  - TAIL (CLK_DIV cycles): all pins 0. On exit: o_done=1 for one cycle, o_busy=0, → IDLE.
- Data changes only in SHIFT_LO, so it is stable ≥CLK_DIV cycles before each rising clk edge.
- Exactly 24 rising pmod_clk edges and exactly one latch pulse per frame.
- Frame length from accept edge to o_done: 50×CLK_DIV cycles (200 at default).
- Bit order: first bit sent = word[23] (ctrl2 bit 11). After 24 shifts the receiver's shift register holds {ctrl2, ctrl1}, so ctrl1 lands in the low 12 bits that gamepad_pmod_single decodes.
- Back-to-back: i_send held high → the next frame is accepted on the cycle IDLE is re-entered, i.e. the cycle after o_done. Frame period is 50×CLK_DIV+1.
- Reset mid-frame: all outputs return to 0 at the next clk edge and state goes to IDLE. No latch is emitted, so the receiver keeps its previous frame.
- Pins are registered outputs; there is no combinational path from inputs to pins.

Decomposition:
- Shared package gamepad_pmod_pkg:
  - button bit-index constants (BTN_B=11 … BTN_R=0)
  - FRAME_BITS=24, CTRL_BITS=12
  - ABSENT_WORD=12'hFFF
  - state enum {IDLE, SHIFT_LO, SHIFT_HI, LATCH, TAIL}
- The package is shared with the receiver.
- No sub-module; phase counter and bit counter stay inline.

Test Plan:
- Reset: hold rst 3 cycles, then idle 10 cycles → all outputs 0, o_busy=0, no pmod_clk edges.
- Loopback into gamepad_pmod_single: send i_buttons1=12'h100, present1=1, present2=0 → o_done at cycle 200. Receiver then shows start=1, is_present=1, all other buttons 0.
- Absent: send with present1=0, i_buttons1=12'h0FF → data is 1 for bits 12..23 of the frame. Receiver shows is_present=0.
- Protocol check: send 24'hA5A5A5. Monitor: exactly 24 rising clk edges, sampled bits equal A5A5A5 MSB-first, one latch pulse of 4 cycles after the last fall. A second i_send at cycle 50 is ignored.
- Reset mid-frame: assert rst during bit 10 → all pins 0 next cycle, no latch, receiver outputs unchanged. A following send completes in 200 cycles.
- Back-to-back: hold i_send=1 for 1000 cycles → o_done every 201 cycles, 4 complete frames, no glitch on latch between frames.
